// File: rtl/wb_regfile.sv
// Writeback stage register file: result mux, write-through bypassed dual read, x10 tap, retire counter.
// Latency: resultw/rd1/rd2 combinational, stored state one cycle; backpressure: none, every writeback commits.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int WRITE_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   regwritew,
    input  logic [1:0]             resultsrcw,
    input  logic [DATA_WIDTH-1:0]  aluresultw,
    input  logic [DATA_WIDTH-1:0]  readdataw,
    input  logic [DATA_WIDTH-1:0]  pcplus4w,
    input  logic [WRITE_WIDTH-1:0] rdw,
    input  logic [WRITE_WIDTH-1:0] a1,
    input  logic [WRITE_WIDTH-1:0] a2,
    output logic [DATA_WIDTH-1:0]  rd1,
    output logic [DATA_WIDTH-1:0]  rd2,
    output logic [DATA_WIDTH-1:0]  resultw,
    output logic [DATA_WIDTH-1:0]  a0,
    output logic [DATA_WIDTH-1:0]  retired
);
    localparam int                   DEPTH  = 2**WRITE_WIDTH;
    localparam logic [WRITE_WIDTH-1:0] A0_IDX = WRITE_WIDTH'(10);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] retired_q;
    logic                  wr_en;
    logic                  byp_en;

    assign wr_en  = regwritew && (rdw != '0);
    // Bypass is masked in reset so readers see the cleared/stored state, not a write that will be dropped.
    assign byp_en = wr_en && !rst;

    always_comb begin
        resultw = '0;
        case (resultsrcw)
            2'b00:   resultw = aluresultw;
            2'b01:   resultw = readdataw;
            2'b10:   resultw = pcplus4w;
            default: resultw = '0;
        endcase
    end

    always_comb begin
        rd1 = '0;
        if (byp_en && (rdw == a1))
            rd1 = resultw;
        else if (a1 != '0)
            rd1 = regs[a1];
    end

    always_comb begin
        rd2 = '0;
        if (byp_en && (rdw == a2))
            rd2 = resultw;
        else if (a2 != '0)
            rd2 = regs[a2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            retired_q <= '0;
        end else begin
            // Counts every committed writeback, including those aimed at x0; wraps silently.
            if (regwritew)
                retired_q <= retired_q + 1'b1;
            if (wr_en)
                regs[rdw] <= resultw;
        end
    end

    assign a0      = regs[A0_IDX];
    assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        regwritew;
    logic [1:0]  resultsrcw;
    logic [31:0] aluresultw, readdataw, pcplus4w;
    logic [4:0]  rdw, a1, a2;
    logic [31:0] rd1, rd2, resultw, a0, retired;

    // narrow instance used to exercise counter wrap in a short run
    logic        rst8, we8;
    logic [7:0]  alu8, rd1_8, rd2_8, res8, a0_8, ret8;
    logic [4:0]  rdw8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_WIDTH(32), .WRITE_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .regwritew(regwritew), .resultsrcw(resultsrcw),
        .aluresultw(aluresultw), .readdataw(readdataw), .pcplus4w(pcplus4w),
        .rdw(rdw), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .resultw(resultw), .a0(a0), .retired(retired)
    );

    wb_regfile #(.DATA_WIDTH(8), .WRITE_WIDTH(5)) dut8 (
        .clk(clk), .rst(rst8), .regwritew(we8), .resultsrcw(2'b00),
        .aluresultw(alu8), .readdataw(8'h00), .pcplus4w(8'h00),
        .rdw(rdw8), .a1(5'd1), .a2(5'd0), .rd1(rd1_8), .rd2(rd2_8),
        .resultw(res8), .a0(a0_8), .retired(ret8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; regwritew = 1'b0; resultsrcw = 2'b00;
        aluresultw = '0; readdataw = '0; pcplus4w = '0;
        rdw = '0; a1 = '0; a2 = '0;
        rst8 = 1'b1; we8 = 1'b0; alu8 = '0; rdw8 = 5'd1;
        step();
        step();
        rst = 1'b0; rst8 = 1'b0;
        a1 = 5'd5;
        #1;
        chk("reset_retired", retired, 32'h0);
        chk("reset_a0", a0, 32'h0);
        chk("reset_rd1_x5", rd1, 32'h0);

        // reserved select drives zero
        resultsrcw = 2'b11; aluresultw = 32'hDEAD; readdataw = 32'hBEEF; pcplus4w = 32'h44;
        #1;
        chk("sel11_zero", resultw, 32'h0);

        // ALU writeback to x5
        regwritew = 1'b1; rdw = 5'd5; resultsrcw = 2'b00; aluresultw = 32'h1234; a1 = 5'd0; a2 = 5'd0;
        #1;
        chk("sel00_alu", resultw, 32'h1234);
        step();
        regwritew = 1'b0; a1 = 5'd5;
        #1;
        chk("x5_stored", rd1, 32'h1234);
        chk("retired_1", retired, 32'd1);

        // write to x0 is dropped but retires
        regwritew = 1'b1; rdw = 5'd0; aluresultw = 32'hFFFF; a1 = 5'd0;
        #1;
        chk("x0_no_bypass", rd1, 32'h0);
        step();
        regwritew = 1'b0;
        #1;
        chk("x0_reads_zero", rd1, 32'h0);
        chk("retired_2", retired, 32'd2);

        // load writeback to x7 bypassed on both ports
        regwritew = 1'b1; rdw = 5'd7; resultsrcw = 2'b01; readdataw = 32'hCAFE; a1 = 5'd7; a2 = 5'd7;
        #1;
        chk("byp_rd1_x7", rd1, 32'hCAFE);
        chk("byp_rd2_x7", rd2, 32'hCAFE);
        step();
        regwritew = 1'b0; a2 = 5'd5;
        #1;
        chk("x7_stored", rd1, 32'hCAFE);
        chk("rd2_x5_stored", rd2, 32'h1234);
        chk("retired_3", retired, 32'd3);

        // link writeback to x10 (a0 is registered, not bypassed)
        regwritew = 1'b1; rdw = 5'd10; resultsrcw = 2'b10; pcplus4w = 32'h104; a1 = 5'd10;
        #1;
        chk("sel10_pc4", resultw, 32'h104);
        chk("a0_not_bypassed", a0, 32'h0);
        chk("byp_rd1_x10", rd1, 32'h104);
        step();
        regwritew = 1'b0;
        #1;
        chk("a0_after_edge", a0, 32'h104);
        chk("retired_4", retired, 32'd4);

        // reset wins over a simultaneous write; bypass suppressed during reset
        rst = 1'b1; regwritew = 1'b1; rdw = 5'd3; resultsrcw = 2'b00; aluresultw = 32'd9;
        a1 = 5'd3; a2 = 5'd5;
        #1;
        chk("rst_no_bypass_x3", rd1, 32'h0);
        chk("rst_rd2_stored_x5", rd2, 32'h1234);
        step();
        rst = 1'b0; regwritew = 1'b0;
        #1;
        chk("rst_x3_zero", rd1, 32'h0);
        chk("rst_x5_zero", rd2, 32'h0);
        chk("rst_retired_zero", retired, 32'h0);
        chk("rst_a0_zero", a0, 32'h0);

        // first write after reset counts as one
        regwritew = 1'b1; rdw = 5'd1; aluresultw = 32'h55; a1 = 5'd1;
        step();
        regwritew = 1'b0;
        #1;
        chk("post_rst_retired_1", retired, 32'd1);
        chk("post_rst_x1", rd1, 32'h55);

        // counter wrap on the 8-bit instance
        we8 = 1'b1; rdw8 = 5'd1;
        for (int i = 0; i < 255; i++) begin
            alu8 = 8'(i);
            step();
        end
        chk("wrap_pre_ff", {24'h0, ret8}, 32'hFF);
        chk("wrap_x1_last", {24'h0, rd1_8}, 32'hFE);
        alu8 = 8'h77;
        step();
        we8 = 1'b0;
        #1;
        chk("wrap_to_zero", {24'h0, ret8}, 32'h0);
        chk("wrap_x1_final", {24'h0, rd1_8}, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
